// File: rtl/runner_pkg.sv
// Shared types and sizing helpers for the runner width converters.
// Consumers: runner_downsizer and runner_beat_select.
package runner_pkg;

  // Downsizer control state: waiting for a word, or streaming its beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } downsizer_state_e;

  // Number of narrow beats per wide word. Clamped to 1 for degenerate
  // configurations so that sizing stays legal while the elaboration
  // check in the top reports the real problem.
  function automatic int beat_ratio(input int width_in, input int width_out);
    int ratio;
    if (width_out <= 0) begin
      ratio = 1;
    end else begin
      ratio = width_in / width_out;
    end
    if (ratio < 1) begin
      ratio = 1;
    end
    return ratio;
  endfunction

  // Width of the beat counter. It is sized to hold values 0..RATIO so the
  // counter never wraps silently, and is at least one bit wide.
  function automatic int beat_cnt_width(input int width_in, input int width_out);
    int w;
    w = $clog2(beat_ratio(width_in, width_out) + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/runner_beat_select.sv
// Beat slice multiplexer for runner_downsizer.
// Picks the WIDTH_OUT-bit slice of the held word addressed by the beat
// counter. Build option RUNNER_DOWNSIZER_MSB_FIRST_EN reverses the slice
// order (most-significant slice first); the default is LSB first.
module runner_beat_select
  import runner_pkg::*;
#(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 4,
  parameter int CNT_W     = beat_cnt_width(WIDTH_IN, WIDTH_OUT)
) (
  input  logic [WIDTH_IN-1:0]  hold,
  input  logic [CNT_W-1:0]     cnt,
  output logic [WIDTH_OUT-1:0] beat
);

  localparam int RATIO = beat_ratio(WIDTH_IN, WIDTH_OUT);

  // Select the slice for the current beat index; out-of-range indices
  // (never reached in normal operation) yield zero.
  always_comb begin
    beat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) begin
`ifdef RUNNER_DOWNSIZER_MSB_FIRST_EN
        beat = hold[(RATIO-1-k)*WIDTH_OUT +: WIDTH_OUT];
`else
        beat = hold[k*WIDTH_OUT +: WIDTH_OUT];
`endif
      end
    end
  end

endmodule

// File: rtl/runner_downsizer.sv
// runner_downsizer: wide-to-narrow width converter on the runner return path.
// Accepts one WIDTH_IN-bit word per valid/ready transfer and emits it as
// WIDTH_IN/WIDTH_OUT WIDTH_OUT-bit beats with a last-beat marker.
// Build option RUNNER_DOWNSIZER_MSB_FIRST_EN selects MSB-first beat order
// (handled in runner_beat_select); handshake and timing are unaffected.
module runner_downsizer
  import runner_pkg::*;
#(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int RATIO = beat_ratio(WIDTH_IN, WIDTH_OUT);
  localparam int CNT_W = beat_cnt_width(WIDTH_IN, WIDTH_OUT);

  // Reject configurations that cannot be split into whole beats.
  if ((WIDTH_OUT <= 0) || (WIDTH_OUT > WIDTH_IN) ||
      ((WIDTH_IN % ((WIDTH_OUT <= 0) ? 1 : WIDTH_OUT)) != 0)) begin : g_bad_cfg
    $error("runner_downsizer: WIDTH_IN (%0d) must be a nonzero multiple of WIDTH_OUT (%0d)",
           WIDTH_IN, WIDTH_OUT);
  end

  downsizer_state_e     state;
  logic [WIDTH_IN-1:0]  hold;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH_OUT-1:0] beat;
  logic                 sending;
  logic                 last_beat;

  // Everything the sink sees is decoded from registered state only.
  assign sending   = (state == SEND);
  assign last_beat = sending && (cnt == CNT_W'(RATIO - 1));
  assign out_valid = sending;
  assign out_last  = last_beat;
  assign out_data  = sending ? beat : '0;

  // A new word is taken when idle, or in the same cycle the final beat of
  // the current word leaves; this keeps back-to-back words bubble-free.
  // Only out_ready feeds in_ready combinationally, never in_valid.
  assign in_ready = (state == IDLE) || (out_ready && last_beat);

  runner_beat_select #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .CNT_W     (CNT_W)
  ) u_beat_select (
    .hold (hold),
    .cnt  (cnt),
    .beat (beat)
  );

  // Control FSM: capture a word, step through its beats on each accepted
  // beat, and either chain the next word or return to IDLE after the last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (!last_beat) begin
              cnt <= cnt + CNT_W'(1);
            end else if (in_valid) begin
              hold <= in_data;
              cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_runner_downsizer.sv
// Bench for runner_downsizer: an 8->4 instance and a 4->4 (ratio 1)
// instance share stimulus; a queue-of-beats reference model predicts every
// output each cycle.
module tb_runner_downsizer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic [3:0] in_data4;

  logic       in_ready, out_valid, out_last;
  logic [3:0] out_data;
  logic       in_ready4, out_valid4, out_last4;
  logic [3:0] out_data4;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0] d;
    logic       last;
  } beat_t;

  beat_t q8[$];
  beat_t q4[$];

  runner_downsizer #(.WIDTH_IN(8), .WIDTH_OUT(4)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  runner_downsizer #(.WIDTH_IN(4), .WIDTH_OUT(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data4),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_last  (out_last4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask

  // Split a word into its beats in emission order and queue them.
  task automatic push8(input logic [7:0] w);
    int idx;
    for (int k = 0; k < 2; k++) begin
`ifdef RUNNER_DOWNSIZER_MSB_FIRST_EN
      idx = 1 - k;
`else
      idx = k;
`endif
      q8.push_back('{d: w[idx*4 +: 4], last: (k == 1)});
    end
  endtask

  // One clock cycle: drive, check predicted outputs mid-cycle, then advance
  // the model by the transfers that the edge performs.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    logic ev8, er8, ev4, er4;
    in_valid  = iv;
    in_data   = d;
    in_data4  = d[3:0];
    out_ready = ordy;
    #2;
    ev8 = (q8.size() != 0);
    er8 = (q8.size() == 0) || (ordy && q8.size() == 1);
    ev4 = (q4.size() != 0);
    er4 = (q4.size() == 0) || (ordy && q4.size() == 1);
    chk("valid8", {7'd0, out_valid}, {7'd0, ev8});
    chk("ready8", {7'd0, in_ready}, {7'd0, er8});
    if (ev8) begin
      chk("data8", {4'd0, out_data}, {4'd0, q8[0].d});
      chk("last8", {7'd0, out_last}, {7'd0, q8[0].last});
    end
    chk("valid4", {7'd0, out_valid4}, {7'd0, ev4});
    chk("ready4", {7'd0, in_ready4}, {7'd0, er4});
    if (ev4) begin
      chk("data4", {4'd0, out_data4}, {4'd0, q4[0].d});
      chk("last4", {7'd0, out_last4}, {7'd0, q4[0].last});
    end
    @(posedge clk);
    if (ev8 && ordy) void'(q8.pop_front());
    if (er8 && iv) push8(d);
    if (ev4 && ordy) void'(q4.pop_front());
    if (er4 && iv) q4.push_back('{d: d[3:0], last: 1'b1});
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_data4  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_last", {7'd0, out_last}, 8'd0);
    chk("rst_data", {4'd0, out_data}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_ready4", {7'd0, in_ready4}, 8'd1);
    reset = 1'b0;
    cycle(1'b0, 8'h00, 1'b1);

    // Basic single word
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Back-to-back with in_valid held
    cycle(1'b1, 8'h12, 1'b1);
    cycle(1'b1, 8'h34, 1'b1);
    cycle(1'b1, 8'h34, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Backpressure for 5 cycles once the first beat shows
    cycle(1'b1, 8'hC3, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-word after the first beat has been taken
    cycle(1'b1, 8'h7E, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_ready", {7'd0, in_ready}, 8'd1);
    chk("midrst_valid4", {7'd0, out_valid4}, 8'd0);
    q8.delete();
    q4.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Ratio-1 style stream of small words (both instances)
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h02, 1'b1);
    cycle(1'b1, 8'h03, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Drain
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
